ccu_draw_seq: RTL and testbench
===============================

# ccu_draw_seq

Parametrised command control unit for the Turbo_GRAFIX drawing path. It accepts a byte-serial command stream over a valid/ready handshake and decodes three opcodes: fill-rectangle, single pixel and clear-screen. For each command it emits one (x, y, colour) pixel write per cycle to the frame-buffer writer, in raster order and under backpressure. It sits between the host command port and the pixel/frame-buffer write stage, and generalises the fixed-width CCU with configurable coordinate width, screen size, multi-byte arguments, corner normalisation, error flagging and flow control.

## Interface
- X_W, 8: x coordinate width in bits, 1..16.
- Y_W, 8: y coordinate width in bits, 1..16.
- COLOR_W, 8: colour width in bits, 1..16.
- SCREEN_W, 256: screen width in pixels, used by CLEAR; must be ≤ 2^X_W.
- SCREEN_H, 256: screen height in pixels, used by CLEAR; must be ≤ 2^Y_W.
- clk  in  1  the block's single clock; all state updates on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- cmd  in  8  command or argument byte.
- cmd_valid  in  1  cmd holds a byte.
- cmd_ready  out  1  block accepts cmd this cycle.
- pix_x  out  X_W  pixel x.
- pix_y  out  Y_W  pixel y.
- pix_color  out  COLOR_W  pixel colour.
- pix_valid  out  1  pixel word valid.
- pix_ready  in  1  downstream accepts the pixel word.
- busy  out  1  a command is in progress (state is not IDLE).
- err  out  1  one-cycle pulse when an unknown opcode is received.

## Operation
- Byte transfer: a byte is transferred on a rising edge when cmd_valid && cmd_ready.
- Pixel transfer: a pixel is transferred on a rising edge when pix_valid && pix_ready.
- Argument byte counts: BX = ceil(X_W/8), BY = ceil(Y_W/8), BC = ceil(COLOR_W/8).
- Multi-byte arguments arrive little-endian. Bits above the field width are discarded.
- Opcodes and arguments, in order:
  - 0x4C FILL: Xs, Ys, Xe, Ye, colour.
  - 0x50 PIXEL: X, Y, colour.
  - 0x43 CLEAR: colour only; the region is 0..SCREEN_W-1 by 0..SCREEN_H-1.
  - Any other opcode: err is high for one cycle, the byte is dropped and the state stays IDLE.
- States:
  - IDLE: cmd_ready=1. A valid opcode moves the state to ARGS with the byte counter cleared.
  - ARGS: cmd_ready=1. Each accepted byte is shifted into the current argument register. After the final argument byte is accepted, the state moves to DRAW.
  - DRAW: cmd_ready=0. Pixels are emitted until the last one is accepted, then the state returns to IDLE.
- Normalisation on ARGS→DRAW:
  - x0 = min(Xs, Xe), x1 = max(Xs, Xe); y0 and y1 are formed the same way.
  - PIXEL uses x0 = x1 = X and y0 = y1 = Y.
- Raster order: x increments fastest from x0 to x1; at x1, x returns to x0 and y increments. The last pixel is (x1, y1).
- Pixel count is (x1-x0+1)*(y1-y0+1). Counters are X_W+1 and Y_W+1 bits wide so the x1 = 2^X_W-1 and y1 = 2^Y_W-1 corners do not wrap early.
- While pix_valid=1 and pix_ready=0, pix_x, pix_y and pix_color hold stable.
- Reset (asynchronous, any state including mid-ARGS or mid-DRAW):
  - State goes to IDLE and partially received arguments are discarded.
  - Output reset values: cmd_ready=0 while rst is high and 1 from the first edge after release; pix_valid=0, pix_x=0, pix_y=0, pix_color=0, busy=0, err=0.

## Timing
- Let edge E accept the last argument byte. After E+1 the state is DRAW, pix_valid=1 and the first pixel (x0, y0) is presented. Command-to-first-pixel latency is one cycle.
- Throughput is one pixel per cycle while pix_ready=1.
- When the last pixel is accepted at edge L: after L, pix_valid=0, busy=0 and cmd_ready=1, so the next opcode can be accepted at edge L+1.
- err rises after the edge that accepts the bad opcode and falls after the following edge.
- busy=1 from the edge that accepts a valid opcode through edge L.
- pix_ready is ignored while pix_valid=0. cmd_valid is ignored while cmd_ready=0.

## Test plan
- PIXEL 0x50, 5, 7, 0x0A with pix_ready=1 -> exactly one word (5, 7, 0x0A), presented one cycle after the colour byte; then busy=0.
- FILL 0x4C, 0, 0, 2, 1, 0x10 with pix_ready toggling 1,0,1,0 -> 6 words in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), each colour 0x10, each held stable while stalled.
- FILL with swapped corners Xs=3, Ys=4, Xe=1, Ye=2 -> 9 words from (1,2) to (3,4) in raster order.
- Opcode 0x99 -> one-cycle err pulse, no pixels, busy stays 0; a following PIXEL command executes normally.
- SCREEN_W=4, SCREEN_H=2, CLEAR 0x43, 0x05 -> 8 words (0,0)..(3,1), colour 5. Separately, X_W=10: FILL with Xs bytes 0x01, 0x02 -> x0 = 0x201.
- Assert rst during the third pixel of a 3x3 FILL -> all outputs 0 immediately; after release a new PIXEL command works.

Source files
------------

// File: rtl/ccu_draw_seq.sv
// ccu_draw_seq: byte-serial command decoder and raster pixel sequencer.
// In: clk, rst, cmd/cmd_valid, pix_ready. Out: cmd_ready, pix_*, busy, err.
module ccu_draw_seq #(
  parameter int X_W      = 8,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 8,
  parameter int SCREEN_W = 256,
  parameter int SCREEN_H = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         cmd,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               busy,
  output logic               err
);

  localparam bit BX2 = (X_W > 8);
  localparam bit BY2 = (Y_W > 8);
  localparam bit BC2 = (COLOR_W > 8);

  localparam logic [X_W-1:0] SX1 = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] SY1 = Y_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ARGS, S_SETUP, S_DRAW
  } state_e;

  typedef enum logic [1:0] {
    OP_FILL, OP_PIX, OP_CLR
  } op_e;

  state_e state_q, state_d;
  op_e    op_q;

  // Field slots: 0=Xs 1=Ys 2=Xe 3=Ye 4=colour.
  // PIXEL skips 2..3, CLEAR starts at 4.
  logic [2:0]         fld_q;
  logic               byte_q;
  logic [X_W-1:0]     xs_q, xe_q;
  logic [Y_W-1:0]     ys_q, ye_q;
  logic [COLOR_W-1:0] col_q;
  logic [X_W-1:0]     x0_q, x1_q;
  logic [Y_W-1:0]     y0_q, y1_q;
  logic [X_W:0]       x_q;
  logic [Y_W:0]       y_q;
  logic               init_q;
  logic               err_q;

  logic        cmd_fire, pix_fire, op_ok;
  logic        fld_two, byte_last, last_arg;
  logic        x_end, y_end;
  logic [15:0] cur, wr;
  logic [X_W-1:0] nx0, nx1;
  logic [Y_W-1:0] ny0, ny1;

  assign cmd_ready = init_q &&
    (state_q == S_IDLE || state_q == S_ARGS);
  assign pix_valid = (state_q == S_DRAW);
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign pix_x     = x_q[X_W-1:0];
  assign pix_y     = y_q[Y_W-1:0];
  assign pix_color = col_q;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign pix_fire = pix_valid && pix_ready;
  assign op_ok    = (cmd == 8'h4C) ||
                    (cmd == 8'h50) ||
                    (cmd == 8'h43);
  assign x_end    = (x_q == {1'b0, x1_q});
  assign y_end    = (y_q == {1'b0, y1_q});

  always_comb begin
    fld_two = BC2;
    cur     = 16'(col_q);
    unique case (fld_q)
      3'd0: begin fld_two = BX2; cur = 16'(xs_q); end
      3'd1: begin fld_two = BY2; cur = 16'(ys_q); end
      3'd2: begin fld_two = BX2; cur = 16'(xe_q); end
      3'd3: begin fld_two = BY2; cur = 16'(ye_q); end
      default: ;
    endcase
  end

  // Little-endian: byte 0 fills [7:0], byte 1 fills [15:8].
  assign wr = byte_q ? {cmd, cur[7:0]}
                     : {cur[15:8], cmd};
  assign byte_last = !fld_two || byte_q;
  assign last_arg  = byte_last && (fld_q == 3'd4);

  always_comb begin
    nx0 = (xs_q < xe_q) ? xs_q : xe_q;
    nx1 = (xs_q < xe_q) ? xe_q : xs_q;
    ny0 = (ys_q < ye_q) ? ys_q : ye_q;
    ny1 = (ys_q < ye_q) ? ye_q : ys_q;
    unique case (op_q)
      OP_PIX: begin
        nx0 = xs_q; nx1 = xs_q;
        ny0 = ys_q; ny1 = ys_q;
      end
      OP_CLR: begin
        nx0 = '0; nx1 = SX1;
        ny0 = '0; ny1 = SY1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (cmd_fire && op_ok) state_d = S_ARGS;
      S_ARGS:
        if (cmd_fire && last_arg) state_d = S_SETUP;
      S_SETUP:
        state_d = S_DRAW;
      S_DRAW:
        if (pix_fire && x_end && y_end) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_FILL;
      fld_q  <= '0;
      byte_q <= 1'b0;
      xs_q   <= '0;
      xe_q   <= '0;
      ys_q   <= '0;
      ye_q   <= '0;
      col_q  <= '0;
      x0_q   <= '0;
      x1_q   <= '0;
      y0_q   <= '0;
      y1_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      init_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      init_q <= 1'b1;
      err_q  <= (state_q == S_IDLE) &&
                cmd_fire && !op_ok;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_fire && op_ok) begin
            byte_q <= 1'b0;
            unique case (cmd)
              8'h50: begin
                op_q  <= OP_PIX;
                fld_q <= 3'd0;
              end
              8'h43: begin
                op_q  <= OP_CLR;
                fld_q <= 3'd4;
              end
              default: begin
                op_q  <= OP_FILL;
                fld_q <= 3'd0;
              end
            endcase
          end
        end
        S_ARGS: begin
          if (cmd_fire) begin
            unique case (fld_q)
              3'd0: xs_q <= X_W'(wr);
              3'd1: ys_q <= Y_W'(wr);
              3'd2: xe_q <= X_W'(wr);
              3'd3: ye_q <= Y_W'(wr);
              default: col_q <= COLOR_W'(wr);
            endcase
            if (byte_last) begin
              byte_q <= 1'b0;
              if (op_q == OP_PIX && fld_q == 3'd1)
                fld_q <= 3'd4;
              else
                fld_q <= fld_q + 3'd1;
            end else begin
              byte_q <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          x0_q <= nx0;
          x1_q <= nx1;
          y0_q <= ny0;
          y1_q <= ny1;
          x_q  <= {1'b0, nx0};
          y_q  <= {1'b0, ny0};
        end
        S_DRAW: begin
          if (pix_fire) begin
            if (x_end) begin
              x_q <= {1'b0, x0_q};
              if (!y_end)
                y_q <= y_q + {{Y_W{1'b0}}, 1'b1};
            end else begin
              x_q <= x_q + {{X_W{1'b0}}, 1'b1};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccu_draw_seq.sv
// tb_ccu_draw_seq: directed bench for ccu_draw_seq.
// Two instances: 8-bit/4x2 screen, and X_W=10.
module tb_ccu_draw_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cmd;
  logic       cmd_valid, cmd_valid1, pix_ready;

  logic       cmd_ready, pix_valid, busy, err;
  logic [7:0] pix_x, pix_y, pix_color;

  logic       cmd_ready1, pix_valid1, busy1, err1;
  logic [9:0] pix_x1;
  logic [7:0] pix_y1, pix_color1;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;
  pix_t expq[$];

  always #5 clk = ~clk;

  ccu_draw_seq #(
    .X_W(8), .Y_W(8), .COLOR_W(8),
    .SCREEN_W(4), .SCREEN_H(2)
  ) u0 (
    .clk(clk), .rst(rst),
    .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .busy(busy), .err(err)
  );

  ccu_draw_seq #(
    .X_W(10), .Y_W(8), .COLOR_W(8),
    .SCREEN_W(4), .SCREEN_H(2)
  ) u1 (
    .clk(clk), .rst(rst),
    .cmd(cmd), .cmd_valid(cmd_valid1),
    .cmd_ready(cmd_ready1),
    .pix_x(pix_x1), .pix_y(pix_y1),
    .pix_color(pix_color1),
    .pix_valid(pix_valid1),
    .pix_ready(pix_ready),
    .busy(busy1), .err(err1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic exp_rect(input int x0, input int y0,
                          input int x1, input int y1,
                          input int c);
    pix_t p;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        p.x = x; p.y = y; p.c = c;
        expq.push_back(p);
      end
  endtask

  task automatic send(input logic [7:0] b,
                      input bit sel1);
    int n;
    @(negedge clk);
    cmd = b;
    if (sel1) cmd_valid1 = 1'b1;
    else      cmd_valid  = 1'b1;
    n = 0;
    while (!(sel1 ? cmd_ready1 : cmd_ready) &&
           n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_valid1 = 1'b0;
  endtask

  // Checks each valid cycle against the queue head,
  // so a stalled word must hold its value.
  task automatic collect(input bit toggle);
    int   n;
    bit   rdy;
    pix_t d;
    n   = 0;
    rdy = 1'b1;
    while (expq.size() > 0 && n < 200) begin
      pix_ready = toggle ? rdy : 1'b1;
      if (pix_valid) begin
        chk("pix_x", 32'(pix_x), expq[0].x);
        chk("pix_y", 32'(pix_y), expq[0].y);
        chk("pix_c", 32'(pix_color), expq[0].c);
        if (pix_ready) d = expq.pop_front();
        if (toggle) rdy = !rdy;
      end
      @(negedge clk);
      n++;
    end
    if (expq.size() > 0)
      chk("collect_timeout", expq.size(), 0);
    expq.delete();
    pix_ready = 1'b1;
    chk("end_valid", pix_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_ready", cmd_ready, 1);
  endtask

  initial begin
    cmd        = 8'h00;
    cmd_valid  = 1'b0;
    cmd_valid1 = 1'b0;
    pix_ready  = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_x", pix_x, 0);
    chk("rst_c", pix_color, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", cmd_ready, 1);

    send(8'h50, 0);
    chk("busy_args", busy, 1);
    send(8'd5, 0);
    send(8'd7, 0);
    send(8'h0A, 0);
    exp_rect(5, 7, 5, 7, 8'h0A);
    @(negedge clk);
    chk("lat_setup", pix_valid, 0);
    chk("lat_rdy", cmd_ready, 0);
    @(negedge clk);
    chk("lat_first", pix_valid, 1);
    collect(0);

    send(8'h4C, 0);
    send(8'd0, 0);
    send(8'd0, 0);
    send(8'd2, 0);
    send(8'd1, 0);
    send(8'h10, 0);
    exp_rect(0, 0, 2, 1, 8'h10);
    collect(1);

    send(8'h4C, 0);
    send(8'd3, 0);
    send(8'd4, 0);
    send(8'd1, 0);
    send(8'd2, 0);
    send(8'h22, 0);
    exp_rect(1, 2, 3, 4, 8'h22);
    collect(0);

    send(8'h99, 0);
    chk("err_hi", err, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    chk("err_lo", err, 0);
    chk("err_nopix", pix_valid, 0);
    send(8'h50, 0);
    send(8'd1, 0);
    send(8'd2, 0);
    send(8'd3, 0);
    exp_rect(1, 2, 1, 2, 3);
    collect(0);

    send(8'h43, 0);
    send(8'h05, 0);
    exp_rect(0, 0, 3, 1, 5);
    collect(0);

    send(8'h4C, 1);
    send(8'h01, 1);
    send(8'h02, 1);
    send(8'h00, 1);
    send(8'h01, 1);
    send(8'hFE, 1);
    send(8'h00, 1);
    send(8'h07, 1);
    @(negedge clk);
    chk("w_setup", pix_valid1, 0);
    @(negedge clk);
    chk("w_valid", pix_valid1, 1);
    chk("w_x", pix_x1, 32'h201);
    chk("w_y", pix_y1, 0);
    chk("w_c", pix_color1, 7);
    @(negedge clk);
    chk("w_done", pix_valid1, 0);
    chk("w_busy", busy1, 0);

    send(8'h4C, 0);
    send(8'd0, 0);
    send(8'd0, 0);
    send(8'd2, 0);
    send(8'd2, 0);
    send(8'd3, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_x", pix_x, 2);
    chk("mid_valid", pix_valid, 1);
    rst = 1'b1;
    #1;
    chk("ar_valid", pix_valid, 0);
    chk("ar_x", pix_x, 0);
    chk("ar_y", pix_y, 0);
    chk("ar_c", pix_color, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_rel", cmd_ready, 1);
    send(8'h50, 0);
    send(8'd9, 0);
    send(8'd3, 0);
    send(8'h44, 0);
    exp_rect(9, 3, 9, 3, 8'h44);
    collect(0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
